// File: rtl/mem_responder.sv
// Memory-side responder: services level-held ReadM/WriteM strobes from a word RAM
// after LATENCY wait states, returning registered data, a MemReady pulse and AddrErr.
module mem_responder #(
    parameter int ADDR_W  = 8,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ReadM,
    input  logic        WriteM,
    input  logic [31:0] Addr,
    input  logic [31:0] Din,
    output logic [31:0] Dout,
    output logic        MemReady,
    output logic        AddrErr
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY    = 2'd1,
        DONE    = 2'd2,
        RELEASE = 2'd3
    } state_t;

    localparam int         DEPTH = 2 ** ADDR_W;
    localparam logic [3:0] LAT_C = 4'(LATENCY);

    state_t              state_r, state_s;
    logic [3:0]          cnt_r, cnt_s;
    logic                op_wr_r, op_wr_s;
    logic [ADDR_W-1:0]   idx_r, idx_s;
    logic                err_r, err_s;
    logic [31:0]         dout_r;
    logic                ready_r;
    logic                aerr_r;
    logic                req_none_s;
    logic [31:0]         ram [0:DEPTH-1];

    // Misaligned, or any address bit above the RAM's byte range is set.
    function automatic logic addr_bad(input logic [31:0] a);
        return (a[1:0] != 2'b00) || ((a >> (ADDR_W + 2)) != 32'd0);
    endfunction

    assign req_none_s = !ReadM && !WriteM;

    // Next-state and request-latch logic.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        op_wr_s = op_wr_r;
        idx_s   = idx_r;
        err_s   = err_r;
        case (state_r)
            IDLE: begin
                if (ReadM && WriteM) begin
                    // Conflicting strobes complete as an erroring write: no RAM access, Dout kept.
                    op_wr_s = 1'b1;
                    err_s   = 1'b1;
                    cnt_s   = 4'd0;
                    state_s = DONE;
                end else if (ReadM ^ WriteM) begin
                    op_wr_s = WriteM;
                    idx_s   = Addr[ADDR_W+1:2];
                    err_s   = addr_bad(Addr);
                    cnt_s   = LAT_C;
                    state_s = (LAT_C == 4'd0) ? DONE : BUSY;
                end else begin
                    state_s = IDLE;
                end
            end
            BUSY: begin
                if (req_none_s) begin
                    cnt_s   = 4'd0;
                    state_s = IDLE;
                end else begin
                    cnt_s   = cnt_r - 4'd1;
                    state_s = (cnt_r <= 4'd1) ? DONE : BUSY;
                end
            end
            DONE: begin
                cnt_s   = 4'd0;
                state_s = RELEASE;
            end
            RELEASE: begin
                // Wait for the strobe to fall so a level-held request cannot re-trigger.
                if (req_none_s) begin
                    state_s = IDLE;
                end else begin
                    state_s = RELEASE;
                end
            end
            default: begin
                cnt_s   = 4'd0;
                state_s = IDLE;
            end
        endcase
    end

    // FSM state, wait counter and latched request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            cnt_r   <= 4'd0;
            op_wr_r <= 1'b0;
            idx_r   <= {ADDR_W{1'b0}};
            err_r   <= 1'b0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            op_wr_r <= op_wr_s;
            idx_r   <= idx_s;
            err_r   <= err_s;
        end
    end

    // Completion outputs, updated at the DONE edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout_r  <= 32'd0;
            ready_r <= 1'b0;
            aerr_r  <= 1'b0;
        end else begin
            ready_r <= (state_r == DONE);
            if (state_r == DONE) begin
                aerr_r <= err_r;
                if (!op_wr_r) begin
                    dout_r <= err_r ? 32'd0 : ram[idx_r];
                end
            end
        end
    end

    // RAM write; Din is sampled at the DONE edge.
    always_ff @(posedge clk) begin
        if (state_r == DONE && op_wr_r && !err_r) begin
            ram[idx_r] <= Din;
        end
    end

    assign Dout     = dout_r;
    assign MemReady = ready_r;
    assign AddrErr  = aerr_r;

endmodule

// File: tb/tb_mem_responder.sv
// Table-driven, scoreboarded bench for mem_responder; three instances cover
// LATENCY=2 (main), LATENCY=0 and LATENCY=3.
module tb_mem_responder;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] din;
        logic [31:0] exp_dout;
        logic        exp_err;
        logic        chk_dout;
    } vec_t;

    typedef struct {
        logic [31:0] dout;
        logic        err;
        logic        chk_dout;
        int          lat;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        read_m    [3];
    logic        write_m   [3];
    logic [31:0] addr      [3];
    logic [31:0] din       [3];
    logic [31:0] dout      [3];
    logic        mem_ready [3];
    logic        addr_err  [3];

    int   checks;
    int   errors;
    exp_t sb [$];
    vec_t vt [14];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        mem_responder #(
            .ADDR_W (8),
            .LATENCY(g == 0 ? 2 : (g == 1 ? 0 : 3))
        ) u_dut (
            .clk     (clk),
            .rst_n   (rst_n),
            .ReadM   (read_m[g]),
            .WriteM  (write_m[g]),
            .Addr    (addr[g]),
            .Din     (din[g]),
            .Dout    (dout[g]),
            .MemReady(mem_ready[g]),
            .AddrErr (addr_err[g])
        );
    end

    always #5 clk = ~clk;

    function automatic int lat_of(input int k);
        case (k)
            0:       return 2;
            1:       return 0;
            default: return 3;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One transaction on instance k; optionally keeps the strobe held for `hold` cycles after MemReady.
    task automatic txn(input int k, input logic rd, input logic wr, input logic [31:0] a,
                       input logic [31:0] d, input logic [31:0] exp_dout, input logic exp_err,
                       input logic chk_dout, input int hold, input string name);
        exp_t e;
        int   n;
        int   extra;
        logic got;
        e.dout     = exp_dout;
        e.err      = exp_err;
        e.chk_dout = chk_dout;
        e.lat      = (rd && wr) ? 1 : lat_of(k) + 1;
        sb.push_back(e);
        @(posedge clk); #1;
        read_m[k]  = rd;
        write_m[k] = wr;
        addr[k]    = a;
        din[k]     = d;
        n   = 0;
        got = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            n++;
            if (mem_ready[k]) begin
                got = 1'b1;
                break;
            end
        end
        e = sb.pop_front();
        chk({name, "_ready_seen"}, 32'(got), 32'd1);
        if (got) begin
            chk({name, "_latency"}, 32'(n - 1), 32'(e.lat));
            chk({name, "_err"}, 32'(addr_err[k]), 32'(e.err));
            if (e.chk_dout) begin
                chk({name, "_dout"}, dout[k], e.dout);
            end
        end
        if (hold > 0) begin
            extra = 0;
            for (int i = 0; i < hold; i++) begin
                @(posedge clk); #1;
                if (mem_ready[k]) extra++;
            end
            chk({name, "_extra_pulses"}, 32'(extra), 32'd0);
            chk({name, "_dout_held"}, dout[k], e.dout);
            chk({name, "_err_held"}, 32'(addr_err[k]), 32'(e.err));
        end
        read_m[k]  = 1'b0;
        write_m[k] = 1'b0;
    endtask

    initial begin
        int pulses;
        checks = 0;
        errors = 0;
        clk    = 1'b0;
        rst_n  = 1'b0;
        for (int k = 0; k < 3; k++) begin
            read_m[k]  = 1'b0;
            write_m[k] = 1'b0;
            addr[k]    = 32'd0;
            din[k]     = 32'd0;
        end

        //           rd    wr    addr          din           exp_dout      err   chk
        vt[0]  = '{1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0, 1'b0};
        vt[1]  = '{1'b1, 1'b0, 32'h0000_0010, 32'h0000_0000, 32'hDEAD_BEEF, 1'b0, 1'b1};
        vt[2]  = '{1'b0, 1'b1, 32'h0000_0014, 32'h1234_5678, 32'h0000_0000, 1'b0, 1'b0};
        vt[3]  = '{1'b1, 1'b0, 32'h0000_0014, 32'h0000_0000, 32'h1234_5678, 1'b0, 1'b1};
        vt[4]  = '{1'b0, 1'b1, 32'h0000_0000, 32'hA5A5_0000, 32'h0000_0000, 1'b0, 1'b0};
        vt[5]  = '{1'b1, 1'b0, 32'h0000_0012, 32'h0000_0000, 32'h0000_0000, 1'b1, 1'b1};
        vt[6]  = '{1'b0, 1'b1, 32'h0000_0400, 32'h0BAD_0BAD, 32'h0000_0000, 1'b1, 1'b1};
        vt[7]  = '{1'b1, 1'b0, 32'h0000_0000, 32'h0000_0000, 32'hA5A5_0000, 1'b0, 1'b1};
        vt[8]  = '{1'b1, 1'b1, 32'h0000_0000, 32'hFFFF_FFFF, 32'hA5A5_0000, 1'b1, 1'b1};
        vt[9]  = '{1'b1, 1'b0, 32'h0000_0000, 32'h0000_0000, 32'hA5A5_0000, 1'b0, 1'b1};
        vt[10] = '{1'b0, 1'b1, 32'h0000_03FC, 32'hCAFE_F00D, 32'h0000_0000, 1'b0, 1'b0};
        vt[11] = '{1'b1, 1'b0, 32'h0000_03FC, 32'h0000_0000, 32'hCAFE_F00D, 1'b0, 1'b1};
        vt[12] = '{1'b1, 1'b0, 32'h8000_0000, 32'h0000_0000, 32'h0000_0000, 1'b1, 1'b1};
        vt[13] = '{1'b0, 1'b1, 32'h0000_0020, 32'h0000_0001, 32'h0000_0000, 1'b0, 1'b0};

        #12;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("rst_dout%0d", k), dout[k], 32'd0);
            chk($sformatf("rst_ready%0d", k), 32'(mem_ready[k]), 32'd0);
            chk($sformatf("rst_err%0d", k), 32'(addr_err[k]), 32'd0);
        end
        rst_n = 1'b1;

        for (int i = 0; i < 14; i++) begin
            txn(0, vt[i].rd, vt[i].wr, vt[i].addr, vt[i].din, vt[i].exp_dout,
                vt[i].exp_err, vt[i].chk_dout, 0, $sformatf("vec%0d", i));
        end

        // Level-held strobe: one pulse only, outputs held.
        txn(0, 1'b1, 1'b0, 32'h0000_0010, 32'h0, 32'hDEAD_BEEF, 1'b0, 1'b1, 10, "hold");
        // Erroring write leaves Dout intact, so reset below has nonzero outputs to clear.
        txn(0, 1'b0, 1'b1, 32'h0000_0404, 32'h0000_0099, 32'hDEAD_BEEF, 1'b1, 1'b1, 0, "errwr");

        // Reset asserted while a write to 0x20 sits in BUSY.
        @(posedge clk); #1;
        write_m[0] = 1'b1;
        addr[0]    = 32'h0000_0020;
        din[0]     = 32'h0000_0077;
        @(posedge clk);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #2;
        chk("busy_rst_dout", dout[0], 32'd0);
        chk("busy_rst_ready", 32'(mem_ready[0]), 32'd0);
        chk("busy_rst_err", 32'(addr_err[0]), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (mem_ready[0]) pulses++;
            if (i == 1) write_m[0] = 1'b0;
        end
        chk("busy_rst_pulses", 32'(pulses), 32'd0);
        txn(0, 1'b1, 1'b0, 32'h0000_0020, 32'h0, 32'h0000_0001, 1'b0, 1'b1, 0, "after_rst");

        // LATENCY=0 instance.
        txn(1, 1'b0, 1'b1, 32'h0000_0004, 32'h55AA_55AA, 32'h0, 1'b0, 1'b0, 0, "l0_wr");
        txn(1, 1'b1, 1'b0, 32'h0000_0004, 32'h0, 32'h55AA_55AA, 1'b0, 1'b1, 0, "l0_rd");

        // LATENCY=3 instance: drop the strobe mid-BUSY.
        @(posedge clk); #1;
        read_m[2] = 1'b1;
        addr[2]   = 32'h0000_0000;
        @(posedge clk);
        @(posedge clk); #1;
        read_m[2] = 1'b0;
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (mem_ready[2]) pulses++;
        end
        chk("abort_pulses", 32'(pulses), 32'd0);
        chk("abort_dout", dout[2], 32'd0);
        chk("abort_err", 32'(addr_err[2]), 32'd0);
        txn(2, 1'b0, 1'b1, 32'h0000_0008, 32'h1357_9BDF, 32'h0, 1'b0, 1'b0, 0, "l3_wr");
        txn(2, 1'b1, 1'b0, 32'h0000_0008, 32'h0, 32'h1357_9BDF, 1'b0, 1'b1, 0, "l3_rd");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
